fingerprint_recorder: RTL and testbench
=======================================

// Module: fingerprint_recorder
// PURPOSE
//  Write side of the matched-filter fingerprint buffer. On arm, captures one burst to compute the signal mean,
//  then captures a second burst and writes the mean-removed, saturated signed samples into fingerprint RAM port B.
//  Sits between the sample capture stream and the dual-port RAM that matched_filter reads on port A.
// PARAMETERS
//  SAMPLE_DATA_WIDTH  8     width of unsigned input samples and of signed stored samples
//  CAPTURE_LENGTH     1000  samples per burst; RAM depth
// PORTS
//  clk        in   1                           clock
//  rst        in   1                           reset, synchronous, active-high
//  arm        in   1                           start pulse; ignored while busy
//  axiiv      in   1                           input sample valid; a burst is a run of consecutive valid cycles
//  axiid      in   SAMPLE_DATA_WIDTH           unsigned input sample
//  wr_en      out  1                           RAM port B write enable
//  wr_addr    out  $clog2(CAPTURE_LENGTH)      RAM port B address
//  wr_data    out  SAMPLE_DATA_WIDTH (signed)  RAM port B data
//  busy       out  1                           high from the cycle after an accepted arm until done
//  done       out  1                           one-cycle pulse after the last write
//  mean_out   out  SAMPLE_DATA_WIDTH           computed mean; holds its value until the next arm
// BEHAVIOUR
//  Reset: state=IDLE. wr_en, busy, done = 0. wr_addr, wr_data, mean_out = 0. Counters and accumulator cleared.
//  States: IDLE -> MEAN -> DIVIDE -> RECORD -> DONE -> IDLE.
//  IDLE: arm=1 -> MEAN, clear accumulator and count. Samples in IDLE are ignored.
//  MEAN: each axiiv=1 cycle adds axiid to sum; count+1.
//   - axiiv=0 before count==CAPTURE_LENGTH -> sum and count cleared; wait for a fresh burst.
//   - count==CAPTURE_LENGTH -> DIVIDE. Further samples of that burst are ignored.
//  SUM_WIDTH = $clog2(CAPTURE_LENGTH*(2**SAMPLE_DATA_WIDTH-1)+1), unsigned; the sum never overflows.
//  DIVIDE: sequential restoring divider, one quotient bit per cycle, exactly SUM_WIDTH cycles.
//   - No combinational '/' operator.
//   - Quotient = floor(sum/CAPTURE_LENGTH); fits in SAMPLE_DATA_WIDTH bits.
//   - On completion: mean_out <= quotient, state -> RECORD, addr counter = 0.
//  RECORD: first axiiv=1 cycle is sample 0. For each valid sample i, one cycle later:
//   - wr_en=1, wr_addr=i, wr_data=sat(axiid-mean).
//   - Diff is computed SAMPLE_DATA_WIDTH+1 bits signed.
//   - sat clamps to [-2**(W-1), 2**(W-1)-1], W = SAMPLE_DATA_WIDTH.
//   - Fixed latency is 1 cycle from sample to write; wr_en=0 on all other cycles.
//   - axiiv=0 mid-burst (0<i<CAPTURE_LENGTH) -> addr counter reset to 0; recording restarts on the next burst,
//     overwriting from address 0. The mean is kept.
//   - After write index CAPTURE_LENGTH-1 -> DONE. Extra samples of the burst are never written.
//  DONE: done=1 for exactly one cycle, busy=0 in that same cycle, state -> IDLE.
//  Address never wraps: wr_addr < CAPTURE_LENGTH always.
//  Simultaneous events:
//   - arm while busy -> ignored.
//   - arm in the DONE cycle -> ignored.
//   - arm in IDLE with axiiv=1 in the same cycle -> that sample is not counted.
//  rst in any state: next cycle wr_en=0, busy=0, done=0, state=IDLE; an in-progress capture is abandoned.
// TESTING (CAPTURE_LENGTH=8, SAMPLE_DATA_WIDTH=8)
//  1. arm; burst of 8x100; burst 100..107
//     -> mean_out=100; writes addr0..7 = 0..7; one done pulse; busy low afterward.
//  2. Mean burst 8x0, record 8x255 -> wr_data=127 (0x7F) at every address.
//     Mean burst 8x255, record 8x0 -> wr_data=-128 (0x80) at every address.
//  3. Mean burst 1,2,1,2,1,2,1,2 (sum 12) -> mean_out=1 (floor). DIVIDE lasts exactly 11 cycles (SUM_WIDTH=11).
//  4. MEAN: 3 valid, 1 gap, then 8x50 -> mean_out=50.
//     RECORD: 5 valid, gap, then 8 valid -> final addr0..7 hold the second burst.
//  5. arm pulse during RECORD -> no effect.
//     rst asserted mid-RECORD after addr3 -> wr_en=0 next cycle, busy=0, no done pulse.
//  6. Burst of 12 samples in RECORD -> exactly 8 writes, addr 0..7; samples 9-12 dropped.

Source files
------------

// File: rtl/fingerprint_recorder_if.sv
// Sample-stream and RAM-port-B bundle for fingerprint_recorder.
// Handshake: axiiv qualifies axiid each cycle; there is no backpressure. wr_en qualifies wr_addr/wr_data.
interface fingerprint_recorder_if #(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int CAPTURE_LENGTH    = 1000
);
    localparam int AW = $clog2(CAPTURE_LENGTH);

    logic                                arm;
    logic                                axiiv;
    logic        [SAMPLE_DATA_WIDTH-1:0] axiid;
    logic                                wr_en;
    logic        [AW-1:0]                wr_addr;
    logic signed [SAMPLE_DATA_WIDTH-1:0] wr_data;
    logic                                busy;
    logic                                done;
    logic        [SAMPLE_DATA_WIDTH-1:0] mean_out;

    modport master (
        output arm, axiiv, axiid,
        input  wr_en, wr_addr, wr_data, busy, done, mean_out
    );

    modport slave (
        input  arm, axiiv, axiid,
        output wr_en, wr_addr, wr_data, busy, done, mean_out
    );
endinterface

// File: rtl/fingerprint_recorder.sv
// Captures a burst to find the mean, then records a second burst as mean-removed,
// saturated signed samples into the fingerprint RAM write port.
module fingerprint_recorder #(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int CAPTURE_LENGTH    = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    fingerprint_recorder_if.slave  bus,
    output logic [2:0]             state_o
);
    localparam int W         = SAMPLE_DATA_WIDTH;
    localparam int N         = CAPTURE_LENGTH;
    localparam int AW        = $clog2(N);
    localparam int CW        = $clog2(N + 1);
    localparam int SUM_WIDTH = $clog2(N * (2**W - 1) + 1);
    localparam int SW        = $clog2(SUM_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MEAN   = 3'd1,
        S_DIVIDE = 3'd2,
        S_RECORD = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        rem_q, rem_d;
    logic [SW-1:0]        step_q, step_d;
    logic [W-1:0]         mean_q, mean_d;
    logic                 wr_en_q, wr_en_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [W-1:0]         wr_data_q, wr_data_d;

    logic [AW:0]          rem_shift;
    logic                 qbit;
    logic [W:0]           diff;
    logic [W-1:0]         sat_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sum_q     <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            step_q    <= '0;
            mean_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            step_q    <= step_d;
            mean_q    <= mean_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        step_d    = step_q;
        mean_d    = mean_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        // Restoring division: the dividend shifts out of sum_q while quotient bits shift in.
        rem_shift = {rem_q, sum_q[SUM_WIDTH-1]};
        qbit      = (rem_shift >= (AW+1)'(N));

        diff = {1'b0, bus.axiid} - {1'b0, mean_q};
        if (diff[W] != diff[W-1]) begin
            sat_val = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sat_val = diff[W-1:0];
        end

        case (state_q)
            S_IDLE: begin
                if (bus.arm) begin
                    state_d = S_MEAN;
                    sum_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_MEAN: begin
                if (bus.axiiv) begin
                    sum_d = sum_q + SUM_WIDTH'(bus.axiid);
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = S_DIVIDE;
                        cnt_d   = '0;
                        rem_d   = '0;
                        step_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    sum_d = '0;
                    cnt_d = '0;
                end
            end
            S_DIVIDE: begin
                sum_d  = {sum_q[SUM_WIDTH-2:0], qbit};
                rem_d  = qbit ? AW'(rem_shift - (AW+1)'(N)) : rem_shift[AW-1:0];
                step_d = step_q + SW'(1);
                if (step_q == SW'(SUM_WIDTH - 1)) begin
                    state_d = S_RECORD;
                    mean_d  = {sum_q[W-2:0], qbit};
                    cnt_d   = '0;
                end
            end
            S_RECORD: begin
                // cnt_q == N means the last write is on the bus this cycle; leave afterwards.
                if (cnt_q == CW'(N)) begin
                    state_d = S_DONE;
                end else if (bus.axiiv) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = AW'(cnt_q);
                    wr_data_d = sat_val;
                    cnt_d     = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.mean_out = mean_q;
    assign bus.busy     = (state_q == S_MEAN) || (state_q == S_DIVIDE) || (state_q == S_RECORD);
    assign bus.done     = (state_q == S_DONE);
    assign state_o      = state_q;
endmodule

// File: tb/tb_fingerprint_recorder.sv
// Directed bench for fingerprint_recorder with CAPTURE_LENGTH=8, SAMPLE_DATA_WIDTH=8.
module tb_fingerprint_recorder;
    localparam int W = 8;
    localparam int N = 8;
    localparam int SUM_W = 11;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_DIVIDE = 3'd2, ST_RECORD = 3'd3, ST_DONE = 3'd4;

    typedef struct {
        int mean_v[8];
        int rec_v[8];
        int exp_mean;
        int exp_data[8];
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;

    fingerprint_recorder_if #(.SAMPLE_DATA_WIDTH(W), .CAPTURE_LENGTH(N)) bus ();

    fingerprint_recorder #(.SAMPLE_DATA_WIDTH(W), .CAPTURE_LENGTH(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int ram_model[N];
    int wr_cnt, done_cnt, div_cycles, wr_last_cyc, wr_last_addr;
    int burst_buf[16];
    int samp_cyc[16];
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (bus.wr_en === 1'b1) begin
            wr_cnt++;
            wr_last_cyc  = cyc;
            wr_last_addr = int'(bus.wr_addr);
            ram_model[bus.wr_addr] = int'($unsigned(bus.wr_data));
            check("wr_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_data_seq", int'($unsigned(bus.wr_data)), int'(e));
            end
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            check("busy_low_in_done", int'(bus.busy), 0);
        end
        if (dbg_state == ST_DIVIDE) div_cycles++;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        wr_cnt = 0;
        done_cnt = 0;
        div_cycles = 0;
        wr_last_cyc = -1;
        wr_last_addr = -1;
        exp_q.delete();
        for (int i = 0; i < N; i++) ram_model[i] = -1;
    endtask

    task automatic send_burst(input int n);
        for (int i = 0; i < n; i++) begin
            bus.axiiv = 1'b1;
            bus.axiid = 8'(burst_buf[i]);
            tick();
            samp_cyc[i] = cyc;
        end
        bus.axiiv = 1'b0;
        tick();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int k = 0;
        while (dbg_state !== s && k < budget) begin
            tick();
            k++;
        end
        check(tag, int'(dbg_state), int'(s));
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        check("busy_after_arm", int'(bus.busy), 1);
    endtask

    task automatic fill_burst(input int base, input int step);
        for (int i = 0; i < 16; i++) burst_buf[i] = base + step * i;
    endtask

    task automatic arm_mean_100();
        clear_sb();
        do_arm();
        fill_burst(100, 0);
        send_burst(N);
        wait_state(ST_RECORD, 40, "reach_record");
        check("mean_100", int'(bus.mean_out), 100);
    endtask

    task automatic check_ram_ramp(input int base);
        for (int a = 0; a < N; a++) check($sformatf("ram[%0d]", a), ram_model[a], base + a);
    endtask

    task automatic run_vector(input int idx);
        clear_sb();
        do_arm();
        for (int i = 0; i < 8; i++) burst_buf[i] = vecs[idx].mean_v[i];
        send_burst(N);
        wait_state(ST_RECORD, 40, "reach_record");
        check("divide_cycles", div_cycles, SUM_W);
        check("mean_out", int'(bus.mean_out), vecs[idx].exp_mean);
        for (int i = 0; i < 8; i++) begin
            burst_buf[i] = vecs[idx].rec_v[i];
            exp_q.push_back(8'(vecs[idx].exp_data[i]));
        end
        send_burst(N);
        tick(); tick(); tick();
        check("wr_count", wr_cnt, N);
        check("done_count", done_cnt, 1);
        check("busy_after", int'(bus.busy), 0);
        check("idle_after", int'(dbg_state), int'(ST_IDLE));
        check("latency", wr_last_cyc, samp_cyc[N-1]);
        for (int a = 0; a < N; a++) check($sformatf("v%0d_ram[%0d]", idx, a), ram_model[a], vecs[idx].exp_data[a]);
    endtask

    initial begin
        bus.arm = 1'b0;
        bus.axiiv = 1'b0;
        bus.axiid = '0;
        rst = 1'b1;
        tick(); tick();
        check("rst_wr_en", int'(bus.wr_en), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_wr_addr", int'(bus.wr_addr), 0);
        check("rst_wr_data", int'($unsigned(bus.wr_data)), 0);
        check("rst_mean", int'(bus.mean_out), 0);
        check("rst_state", int'(dbg_state), int'(ST_IDLE));
        rst = 1'b0;
        tick();

        vecs[0].mean_v = '{100, 100, 100, 100, 100, 100, 100, 100};
        vecs[0].rec_v = '{100, 101, 102, 103, 104, 105, 106, 107};
        vecs[0].exp_mean = 100;
        vecs[0].exp_data = '{0, 1, 2, 3, 4, 5, 6, 7};
        vecs[1].mean_v = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1].rec_v = '{255, 255, 255, 255, 255, 255, 255, 255};
        vecs[1].exp_mean = 0;
        vecs[1].exp_data = '{127, 127, 127, 127, 127, 127, 127, 127};
        vecs[2].mean_v = '{255, 255, 255, 255, 255, 255, 255, 255};
        vecs[2].rec_v = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].exp_mean = 255;
        vecs[2].exp_data = '{128, 128, 128, 128, 128, 128, 128, 128};
        vecs[3].mean_v = '{1, 2, 1, 2, 1, 2, 1, 2};
        vecs[3].rec_v = '{0, 1, 2, 3, 130, 200, 255, 128};
        vecs[3].exp_mean = 1;
        vecs[3].exp_data = '{255, 0, 1, 2, 127, 127, 127, 127};
        vecs[4].mean_v = '{10, 20, 30, 40, 50, 60, 70, 80};
        vecs[4].rec_v = '{45, 0, 173, 172, 200, 17, 16, 90};
        vecs[4].exp_mean = 45;
        vecs[4].exp_data = '{0, 211, 127, 127, 127, 228, 227, 45};
        vecs[5].mean_v = '{255, 255, 255, 255, 255, 255, 255, 254};
        vecs[5].rec_v = '{0, 126, 127, 255, 254, 200, 1, 128};
        vecs[5].exp_mean = 254;
        vecs[5].exp_data = '{128, 128, 129, 1, 0, 202, 128, 130};

        for (int v = 0; v < 6; v++) run_vector(v);

        // gaps in both bursts: partial bursts are discarded
        clear_sb();
        do_arm();
        fill_burst(7, 0);
        send_burst(3);
        fill_burst(50, 0);
        send_burst(N);
        wait_state(ST_RECORD, 40, "gap_reach_record");
        check("gap_mean", int'(bus.mean_out), 50);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(207 + i));
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(10 + i));
        fill_burst(1, 1);
        send_burst(5);
        fill_burst(60, 1);
        send_burst(N);
        tick(); tick(); tick();
        check("gap_wr_count", wr_cnt, 13);
        check("gap_done_count", done_cnt, 1);
        check_ram_ramp(10);

        // arm during RECORD and during DONE is ignored
        arm_mean_100();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < N; i++) begin
            bus.axiiv = 1'b1;
            bus.axiid = 8'(100 + i);
            bus.arm = (i == 2);
            tick();
        end
        bus.arm = 1'b0;
        bus.axiiv = 1'b0;
        wait_state(ST_DONE, 10, "arm_reach_done");
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        tick();
        check("arm_in_done_state", int'(dbg_state), int'(ST_IDLE));
        check("arm_in_done_busy", int'(bus.busy), 0);
        check("arm_done_count", done_cnt, 1);
        check("arm_wr_count", wr_cnt, N);
        check_ram_ramp(0);

        // reset mid-RECORD after addr 3
        arm_mean_100();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
        fill_burst(100, 1);
        for (int i = 0; i < 4; i++) begin
            bus.axiiv = 1'b1;
            bus.axiid = 8'(burst_buf[i]);
            tick();
        end
        rst = 1'b1;
        bus.axiid = 8'd104;
        tick();
        check("rst_mid_wr_en", int'(bus.wr_en), 0);
        check("rst_mid_busy", int'(bus.busy), 0);
        check("rst_mid_state", int'(dbg_state), int'(ST_IDLE));
        check("rst_mid_mean", int'(bus.mean_out), 0);
        rst = 1'b0;
        bus.axiiv = 1'b0;
        tick(); tick(); tick(); tick();
        check("rst_mid_done", done_cnt, 0);
        check("rst_mid_wr_count", wr_cnt, 4);
        check("rst_mid_idle", int'(dbg_state), int'(ST_IDLE));

        // overlong burst: only the first N samples are written
        arm_mean_100();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
        fill_burst(100, 1);
        send_burst(12);
        tick(); tick(); tick();
        check("long_wr_count", wr_cnt, N);
        check("long_done_count", done_cnt, 1);
        check("long_last_addr", wr_last_addr, N - 1);
        check("long_latency", wr_last_cyc, samp_cyc[N-1]);
        check("long_exp_q_empty", exp_q.size(), 0);
        check_ram_ramp(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
